// File: rtl/seg_rx.sv
// seg_rx: receive-side decoder for the serial 7-segment display link.
// Reassembles 16-bit 595-style frames into a 32-bit hex value and dp mask.
module seg_rx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        sdata,
    input  logic        stclk,
    output logic [31:0] value,
    output logic [7:0]  dp,
    output logic        valid,
    output logic        err
);

    localparam logic [7:0] SEG_TBL [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    // Bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge history).
    logic [2:0]  sclk_q;
    logic [2:0]  stclk_q;
    logic [1:0]  sdata_q;

    logic [15:0] sr;
    logic [4:0]  bitcnt;
    logic [31:0] digits;
    logic [7:0]  dpr;
    logic [7:0]  seen;

    logic        shift_ev;
    logic        latch_ev;
    logic [7:0]  sel_n;
    logic [7:0]  seg;
    logic        onehot;
    logic [2:0]  idx;
    logic        hit;
    logic [3:0]  nib;
    logic        accept;
    logic        done;
    logic [7:0]  seen_nxt;
    logic [31:0] digit_nxt;
    logic [7:0]  dpr_nxt;

    assign shift_ev = sclk_q[1] & ~sclk_q[2];
    assign latch_ev = stclk_q[1] & ~stclk_q[2];
    assign sel_n    = ~sr[15:8];
    assign seg      = sr[7:0];

    // Equal-depth synchronizers keep data aligned with the clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q  <= '0;
            stclk_q <= '0;
            sdata_q <= '0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sclk};
            stclk_q <= {stclk_q[1:0], stclk};
            sdata_q <= {sdata_q[0], sdata};
        end
    end

    // Frame checks: one-hot select and segment pattern lookup.
    always_comb begin
        onehot = (sel_n != 8'h00) && ((sel_n & (sel_n - 8'd1)) == 8'h00);
        idx    = 3'd0;
        hit    = 1'b0;
        nib    = 4'd0;
        for (int n = 0; n < 8; n++) begin
            if (sel_n[n]) begin
                idx = 3'(n);
            end
        end
        for (int n = 0; n < 16; n++) begin
            if (seg[7:1] == SEG_TBL[n][7:1]) begin
                hit = 1'b1;
                nib = 4'(n);
            end
        end
    end

    // Next digit-set contents if the current latch is accepted.
    always_comb begin
        accept    = latch_ev && (bitcnt == 5'd16) && onehot && hit;
        seen_nxt  = seen | (8'h01 << idx);
        done      = accept && (seen_nxt == 8'hFF);
        digit_nxt = digits;
        dpr_nxt   = dpr;
        digit_nxt[{idx, 2'b00} +: 4] = nib;
        dpr_nxt[idx] = ~seg[0];
    end

    // Shift register and bit counter; a coincident latch sees old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            bitcnt <= '0;
        end else if (shift_ev) begin
            sr <= {sdata_q[1], sr[15:1]};
            if (latch_ev) begin
                bitcnt <= 5'd1;
            end else if (bitcnt != 5'd31) begin
                bitcnt <= bitcnt + 5'd1;
            end
        end else if (latch_ev) begin
            bitcnt <= '0;
        end
    end

    // Collect accepted digits until all eight positions are seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits <= '0;
            dpr    <= '0;
            seen   <= '0;
        end else if (accept) begin
            digits <= digit_nxt;
            dpr    <= dpr_nxt;
            seen   <= done ? 8'h00 : seen_nxt;
        end
    end

    // Registered outputs: pulses and the published digit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            dp    <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= done;
            err   <= latch_ev & ~accept;
            if (done) begin
                value <= digit_nxt;
                dp    <= dpr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg_rx.sv
// tb_seg_rx: table-driven, hand-sequenced and randomized checks of seg_rx.
// Random frames are judged by a digit-set model built from the link rules.
module tb_seg_rx;

    localparam logic [7:0] TBL [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    typedef struct {
        logic [7:0]  sel;
        logic [7:0]  seg;
        int          nbits;
        logic        eerr;
        logic        evalid;
        logic [31:0] evalue;
        logic [7:0]  edp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        sdata;
    logic        stclk;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        valid;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    vec_t tbl[$];

    logic [3:0]  m_dig [8];
    logic        m_dpl [8];
    logic        m_seen [8];
    logic [31:0] m_value;
    logic [7:0]  m_dpo;

    seg_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclk  (sclk),
        .sdata (sdata),
        .stclk (stclk),
        .value (value),
        .dp    (dp),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (valid) valid_cnt = valid_cnt + 1;
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dsel(input int i);
        logic [7:0] m;
        m = 8'h01 << i;
        return ~m;
    endfunction

    function automatic vec_t mk(input logic [7:0] sel, input logic [7:0] seg,
                                input int nb, input logic ee, input logic ev,
                                input logic [31:0] eval, input logic [7:0] edp);
        vec_t v;
        v.sel = sel; v.seg = seg; v.nbits = nb; v.eerr = ee;
        v.evalid = ev; v.evalue = eval; v.edp = edp;
        return v;
    endfunction

    task automatic shift_bit(input logic b);
        sdata = b;
        repeat (4) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (4) @(posedge clk);
        #1 sclk = 1'b0;
    endtask

    task automatic do_latch(output logic lv, output logic le);
        repeat (4) @(posedge clk);
        #1 stclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 lv = valid; le = err;
        @(posedge clk);
        #1 stclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic apply_frame(input logic [7:0] sel, input logic [7:0] seg,
                               input int nbits, output logic lv, output logic le,
                               output int cv, output int ce);
        logic [15:0] fr;
        int v0;
        int e0;
        fr = {sel, seg};
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int b = 0; b < nbits; b++) begin
            shift_bit(b < 16 ? fr[b] : 1'b0);
        end
        do_latch(lv, le);
        cv = valid_cnt - v0;
        ce = err_cnt - e0;
    endtask

    task automatic model_reset();
        for (int j = 0; j < 8; j++) begin
            m_dig[j] = 4'd0; m_dpl[j] = 1'b0; m_seen[j] = 1'b0;
        end
        m_value = 32'd0;
        m_dpo = 8'd0;
    endtask

    task automatic model_frame(input logic [7:0] sel, input logic [7:0] seg,
                               input int nbits, output logic ee,
                               output logic ev);
        logic [7:0] x;
        int pos;
        int nb;
        bit all;
        x = ~sel;
        pos = -1;
        nb = -1;
        ee = 1'b0;
        ev = 1'b0;
        for (int j = 0; j < 8; j++) if (x[j]) pos = j;
        for (int n = 0; n < 16; n++) begin
            if ((seg >> 1) == (TBL[n] >> 1)) nb = n;
        end
        if (nbits != 16 || $countones(x) != 1 || nb < 0) begin
            ee = 1'b1;
            return;
        end
        m_dig[pos] = 4'(nb);
        m_dpl[pos] = ~seg[0];
        m_seen[pos] = 1'b1;
        all = 1'b1;
        for (int j = 0; j < 8; j++) if (!m_seen[j]) all = 1'b0;
        if (all) begin
            ev = 1'b1;
            for (int j = 0; j < 8; j++) begin
                m_value[4*j +: 4] = m_dig[j];
                m_dpo[j] = m_dpl[j];
                m_seen[j] = 1'b0;
            end
        end
    endtask

    initial begin
        logic lv;
        logic le;
        int cv;
        int ce;
        logic [15:0] fx;
        logic [15:0] fy;
        logic [31:0] ev;

        rst_n = 1'b0; sclk = 1'b0; sdata = 1'b0; stclk = 1'b0;

        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(dsel(i), TBL[i+1], 16, 1'b0, i == 7,
                             i == 7 ? 32'h87654321 : 32'h0, 8'h00));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(dsel(i), i == 3 ? 8'h70 : TBL[i+1], 16, 1'b0,
                             i == 7, i == 7 ? 32'h8765F321 : 32'h87654321,
                             i == 7 ? 8'h08 : 8'h00));
        tbl.push_back(mk(dsel(0), TBL[1], 15, 1'b1, 1'b0, 32'h8765F321, 8'h08));
        tbl.push_back(mk(dsel(0), TBL[1], 16, 1'b0, 1'b0, 32'h8765F321, 8'h08));
        tbl.push_back(mk(8'hFC, TBL[2], 16, 1'b1, 1'b0, 32'h8765F321, 8'h08));
        tbl.push_back(mk(dsel(2), 8'hFF, 16, 1'b1, 1'b0, 32'h8765F321, 8'h08));
        tbl.push_back(mk(dsel(0), TBL[10], 16, 1'b0, 1'b0, 32'h8765F321, 8'h08));
        tbl.push_back(mk(dsel(0), TBL[11], 16, 1'b0, 1'b0, 32'h8765F321, 8'h08));
        for (int i = 1; i < 8; i++)
            tbl.push_back(mk(dsel(i), TBL[0], 16, 1'b0, i == 7,
                             i == 7 ? 32'h0000000B : 32'h8765F321,
                             i == 7 ? 8'h00 : 8'h08));

        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset value", value, 32'h0);
        chk("reset dp", {24'h0, dp}, 32'h0);
        chk("reset valid", {31'h0, valid}, 32'h0);
        chk("reset err", {31'h0, err}, 32'h0);

        foreach (tbl[r]) begin
            apply_frame(tbl[r].sel, tbl[r].seg, tbl[r].nbits, lv, le, cv, ce);
            chk($sformatf("row%0d err_at_k+2", r), {31'h0, le}, {31'h0, tbl[r].eerr});
            chk($sformatf("row%0d err_count", r), cv == cv ? ce : 0, {31'h0, tbl[r].eerr});
            chk($sformatf("row%0d valid_at_k+2", r), {31'h0, lv}, {31'h0, tbl[r].evalid});
            chk($sformatf("row%0d valid_count", r), cv, {31'h0, tbl[r].evalid});
            chk($sformatf("row%0d value", r), value, tbl[r].evalue);
            chk($sformatf("row%0d dp", r), {24'h0, dp}, {24'h0, tbl[r].edp});
        end

        // Coincident shift and latch: frame X latches, frame Y starts at 1.
        fx = {dsel(0), TBL[5]};
        fy = {dsel(1), TBL[6]};
        ce = err_cnt;
        for (int b = 0; b < 16; b++) shift_bit(fx[b]);
        sdata = fy[0];
        repeat (4) @(posedge clk);
        #1 sclk = 1'b1; stclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 le = err;
        @(posedge clk);
        #1 sclk = 1'b0; stclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("coincident latch err", {31'h0, le}, 32'h0);
        for (int b = 1; b < 16; b++) shift_bit(fy[b]);
        do_latch(lv, le);
        chk("after coincident err", {31'h0, le}, 32'h0);
        for (int i = 2; i < 8; i++) begin
            apply_frame(dsel(i), TBL[0], 16, lv, le, cv, ce);
        end
        chk("coincident set valid", {31'h0, lv}, 32'h1);
        chk("coincident set value", value, 32'h00000065);

        // Reset in the middle of a frame.
        fx = {dsel(3), TBL[7]};
        for (int b = 0; b < 10; b++) shift_bit(fx[b]);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset value", value, 32'h0);
        chk("midreset dp", {24'h0, dp}, 32'h0);
        chk("midreset valid", {31'h0, valid}, 32'h0);
        chk("midreset err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            apply_frame(dsel(i), TBL[9], 16, lv, le, cv, ce);
            chk($sformatf("nines%0d err", i), ce, 32'h0);
            chk($sformatf("nines%0d valid", i), cv, i == 7 ? 32'h1 : 32'h0);
            chk($sformatf("nines%0d value", i), value,
                i == 7 ? 32'h99999999 : 32'h0);
        end

        // Randomized frames against the digit-set model.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int t = 0; t < 80; t++) begin
            int mode;
            int i;
            int nb;
            logic [7:0] sel;
            logic [7:0] seg;
            logic ee;
            logic evd;
            mode = $urandom_range(9);
            i = ($urandom_range(3) != 0) ? (t % 8) : $urandom_range(7);
            nb = 16;
            sel = dsel(i);
            seg = {TBL[$urandom_range(15)][7:1], 1'($urandom_range(1))};
            if (mode == 0) sel = 8'($urandom);
            if (mode == 1) seg = 8'($urandom);
            if (mode == 2) nb = ($urandom_range(1) != 0) ? 17 : 15;
            model_frame(sel, seg, nb, ee, evd);
            apply_frame(sel, seg, nb, lv, le, cv, ce);
            ev = m_value;
            chk($sformatf("rnd%0d err", t), ce, {31'h0, ee});
            chk($sformatf("rnd%0d valid", t), cv, {31'h0, evd});
            chk($sformatf("rnd%0d value", t), value, ev);
            chk($sformatf("rnd%0d dp", t), {24'h0, dp}, {24'h0, m_dpo});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
